// File: rtl/dot_product_mac_pipe.sv
// Pipelined signed dot-product engine with valid/ready flow control.
// Each beat multiplies N element pairs and reduces them through a registered
// adder tree. Tree sums are accumulated from in_first through in_last.
// Every register, including the result, holds while the output is stalled.

// One lane: registered signed product of a single element pair.
module dot_product_mac_lane #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] p
);
  logic [2*DW-1:0] ax, bx;

  // Sign-extend both operands so the low 2*DW bits of the product are exact.
  assign ax = {{DW{a[DW-1]}}, a};
  assign bx = {{DW{b[DW-1]}}, b};

  // Product register; it advances only when the pipe is not stalled.
  always_ff @(posedge clk or posedge rst)
    if (rst)     p <= '0;
    else if (en) p <= ax * bx;
endmodule

module dot_product_mac_pipe #(
  parameter int N    = 16,
  parameter int DW   = 32,
  parameter int ACCW = 72,
  parameter bit SAT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   vec_a,
  input  logic [N*DW-1:0]   vec_b,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACCW-1:0]   result,
  output logic              overflow
);
  localparam int T  = $clog2(N);
  localparam int SW = 2*DW + T;
  // The exact sum can need more bits than ACCW when ACCW is narrower than the
  // full tree sum, so the add is done one bit wider than either operand.
  localparam int WW = ((ACCW > SW) ? ACCW : SW) + 1;
  localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  logic en;
  logic [T:0] vld_pipe, fst_pipe, lst_pipe;
  logic [N-1:0][2*DW-1:0] prod;

  // A held result blocks the whole pipe.
  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  // Valid and first/last tags, one entry per stage: 0 is products, T is the root.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe <= '0;
      fst_pipe <= '0;
      lst_pipe <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[T-1:0], in_valid};
      fst_pipe <= {fst_pipe[T-1:0], in_first};
      lst_pipe <= {lst_pipe[T-1:0], in_last};
    end

  for (genvar g = 0; g < N; g++) begin : g_lane
    dot_product_mac_lane #(.DW(DW)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (vec_a[g*DW +: DW]),
      .b   (vec_b[g*DW +: DW]),
      .p   (prod[g])
    );
  end

  // Adder tree: level l has N>>l nodes, each one bit wider than its children.
  for (genvar l = 0; l <= T; l++) begin : lvl
    logic [(N>>l)-1:0][2*DW+l-1:0] sum;
    if (l == 0) begin : g_leaf
      assign sum = prod;
    end else begin : g_node
      // Pairwise sign-extended add of the previous level.
      always_ff @(posedge clk or posedge rst)
        if (rst) sum <= '0;
        else if (en)
          for (int i = 0; i < (N>>l); i++)
            sum[i] <= {lvl[l-1].sum[2*i][2*DW+l-2],   lvl[l-1].sum[2*i]}
                    + {lvl[l-1].sum[2*i+1][2*DW+l-2], lvl[l-1].sum[2*i+1]};
    end
  end

  logic [SW-1:0]   tsum;
  logic [WW-1:0]   base_w, s_w, sum_w;
  logic [ACCW-1:0] acc, acc_nx;
  logic            beat_ovf, ovf_sticky;

  assign tsum = lvl[T].sum[0];

  // Accumulate add: a first beat starts from zero; overflow means the exact
  // sum does not fit in ACCW bits; saturate or wrap depending on SAT.
  always_comb begin
    base_w   = fst_pipe[T] ? '0 : WW'($signed(acc));
    s_w      = WW'($signed(tsum));
    sum_w    = base_w + s_w;
    beat_ovf = (sum_w != WW'($signed(sum_w[ACCW-1:0])));
    acc_nx   = sum_w[ACCW-1:0];
    if (SAT && beat_ovf)
      acc_nx = sum_w[WW-1] ? ACC_MIN : ACC_MAX;
  end

  // Accumulator and result registers; bubbles leave acc untouched.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
    end else if (en) begin
      out_valid <= vld_pipe[T] & lst_pipe[T];
      if (vld_pipe[T]) begin
        acc <= acc_nx;
        if (lst_pipe[T]) begin
          result     <= acc_nx;
          overflow   <= ovf_sticky | beat_ovf;
          ovf_sticky <= 1'b0;
        end else begin
          ovf_sticky <= ovf_sticky | beat_ovf;
        end
      end
    end
endmodule
